// File: rtl/rtc_bus_pkg.sv
// -----------------------------------------------------------------------------
// rtc_bus_pkg
// Shared definitions for the RTC bus arbiter slice:
//   - rtc_state_e : bus sequencer state enumeration
//   - BUS_IDLE    : value driven on adout whenever the bus is not driven
//   - NUM_REQ     : number of requesters sharing the RTC bus
//   - helpers     : one-hot priority pick, byte lane select, round-robin
//                   restart point after a grant
// -----------------------------------------------------------------------------
package rtc_bus_pkg;

    localparam int         NUM_REQ  = 3;
    localparam logic [7:0] BUS_IDLE = 8'hFF;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        GRANT = 4'd1,
        A_AD  = 4'd2,
        A_CS  = 4'd3,
        A_STB = 4'd4,
        A_END = 4'd5,
        GAPW  = 4'd6,
        D_CS  = 4'd7,
        D_STB = 4'd8,
        D_END = 4'd9,
        DONE  = 4'd10
    } rtc_state_e;

    // Lowest-index set bit as a one-hot vector (bit 0 has highest priority).
    function automatic logic [2:0] lowest_one(input logic [2:0] v);
        logic [2:0] r;
        if (v[0]) begin
            r = 3'b001;
        end else if (v[1]) begin
            r = 3'b010;
        end else if (v[2]) begin
            r = 3'b100;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Select the byte lane of a packed per-requester bus by a one-hot select.
    function automatic logic [7:0] byte_sel(input logic [23:0] bus, input logic [2:0] sel);
        logic [7:0] r;
        case (sel)
            3'b001:  r = bus[7:0];
            3'b010:  r = bus[15:8];
            3'b100:  r = bus[23:16];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Index at which the next round-robin search starts, i.e. the one just
    // above the requester that was granted (wrapping 2 -> 0).
    function automatic logic [1:0] next_start(input logic [2:0] sel);
        logic [1:0] r;
        case (sel)
            3'b001:  r = 2'd1;
            3'b010:  r = 2'd2;
            3'b100:  r = 2'd0;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rtc_req_picker.sv
// -----------------------------------------------------------------------------
// rtc_req_picker
// Combinational winner selection. The search starts at index ptr and walks
// upward with wrap; ptr = 0 gives plain fixed priority (0 highest).
// Ports:
//   req   [2:0] in  : request vector, bit i = requester i
//   ptr   [1:0] in  : index searched first (0..2)
//   grant [2:0] out : one-hot winner, all zero when no request
// -----------------------------------------------------------------------------
module rtc_req_picker
    import rtc_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [2:0] rot_s;
    logic [2:0] pick_s;

    // Rotate requests so the start index sits at bit 0, pick, rotate back.
    always_comb begin
        rot_s  = req;
        pick_s = 3'b000;
        grant  = 3'b000;
        case (ptr)
            2'd1: begin
                rot_s  = {req[0], req[2], req[1]};
                pick_s = lowest_one(rot_s);
                grant  = {pick_s[1], pick_s[0], pick_s[2]};
            end
            2'd2: begin
                rot_s  = {req[1], req[0], req[2]};
                pick_s = lowest_one(rot_s);
                grant  = {pick_s[0], pick_s[2], pick_s[1]};
            end
            default: begin
                rot_s  = req;
                pick_s = lowest_one(rot_s);
                grant  = pick_s;
            end
        endcase
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_bus_arbiter
// Arbitrates three requesters onto a multiplexed, active-low RTC bus. Each
// transaction runs an address phase (ad, cs, wr strobe with the address on
// adout), an idle gap, and a data phase (cs plus wr or rd strobe), then pulses
// ack to the served requester.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (search
// starts just above the last-served requester). Without it, fixed priority
// with requester 0 highest and no pointer register.
//
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   req/we [2:0]     : per-requester request level and direction (1 = write)
//   addr/wdata [23:0]: per-requester address / write data, byte i = req i
//   ack [2:0]        : one-cycle completion pulse to the served requester
//   rdata [7:0]      : read data, valid while ack pulses for a read
//   busy             : high from grant until the ack cycle
//   ad, cs, wr, rd   : active-low bus strobes
//   adout, adoe      : bus drive value and drive enable
//   adin             : bus sample
// All outputs are registered.
// -----------------------------------------------------------------------------
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int ADDR_HOLD = 5,
    parameter int DATA_HOLD = 5,
    parameter int GAP       = 8
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   we,
    input  logic [NUM_REQ*8-1:0] addr,
    input  logic [NUM_REQ*8-1:0] wdata,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic                 ad,
    output logic                 cs,
    output logic                 wr,
    output logic                 rd,
    output logic [7:0]           adout,
    output logic                 adoe,
    input  logic [7:0]           adin
);

    // The counter also sequences the 3-step A_END release, so it needs at
    // least the range 0..2 even for tiny hold parameters.
    localparam int MAX_HA  = (ADDR_HOLD > DATA_HOLD) ? ADDR_HOLD : DATA_HOLD;
    localparam int MAX_HG  = (MAX_HA > GAP) ? MAX_HA : GAP;
    localparam int MAX_CNT = (MAX_HG > 3) ? MAX_HG : 3;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_HOLD - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] AEND_LAST = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEND_LAST = CNT_W'(1);

    rtc_state_e         state_r;
    rtc_state_e         state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [2:0]         grant_s;
    logic [1:0]         ptr_s;
    logic               start_s;
    logic [2:0]         win_r;
    logic               we_r;
    logic [7:0]         addr_r;
    logic [7:0]         wdata_r;

    logic               ad_s;
    logic               cs_s;
    logic               wr_s;
    logic               rd_s;
    logic [7:0]         adout_s;
    logic               adoe_s;
    logic [2:0]         ack_s;
    logic               busy_s;

    assign start_s = (state_r == IDLE) && (|req);

    rtc_req_picker u_picker (
        .req   (req),
        .ptr   (ptr_s),
        .grant (grant_s)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_r;

    // Round-robin start index: moves just past each new winner.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= 2'd0;
        end else if (start_s) begin
            ptr_r <= next_start(grant_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = 2'd0;
`endif

    // Latch winner, direction, address and data once; they stay fixed until
    // the next transaction starts.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_r   <= 3'b000;
            we_r    <= 1'b0;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
        end else if (start_s) begin
            win_r   <= grant_s;
            we_r    <= |(we & grant_s);
            addr_r  <= byte_sel(addr, grant_s);
            wdata_r <= byte_sel(wdata, grant_s);
        end else begin
            win_r   <= win_r;
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Next-state and phase counter; the counter restarts at zero on every
    // state change and stops at each state's last count, so it never wraps.
    always_comb begin
        state_s = state_r;
        cnt_s   = CNT_ZERO;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: state_s = A_AD;
            A_AD:  state_s = A_CS;
            A_CS:  state_s = A_STB;
            A_STB: begin
                if (cnt_r == ADDR_LAST) begin
                    state_s = A_END;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            A_END: begin
                if (cnt_r == AEND_LAST) begin
                    state_s = GAPW;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            GAPW: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = D_CS;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            D_CS:  state_s = D_STB;
            D_STB: begin
                if (cnt_r == DATA_LAST) begin
                    state_s = D_END;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            D_END: begin
                if (cnt_r == DEND_LAST) begin
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Bus values for the coming cycle, decoded from the next state so the
    // registered outputs line up with the state register. On the cycle a
    // strobe rises the driven value is kept one more cycle as hold time.
    always_comb begin
        ad_s    = 1'b1;
        cs_s    = 1'b1;
        wr_s    = 1'b1;
        rd_s    = 1'b1;
        adout_s = BUS_IDLE;
        adoe_s  = 1'b0;
        case (state_s)
            A_AD: begin
                ad_s = 1'b0;
            end
            A_CS: begin
                ad_s = 1'b0;
                cs_s = 1'b0;
            end
            A_STB: begin
                ad_s    = 1'b0;
                cs_s    = 1'b0;
                wr_s    = 1'b0;
                adoe_s  = 1'b1;
                adout_s = addr_r;
            end
            A_END: begin
                // Release order: wr, then cs, then ad on successive cycles.
                if (cnt_s == CNT_ZERO) begin
                    ad_s    = 1'b0;
                    cs_s    = 1'b0;
                    adoe_s  = 1'b1;
                    adout_s = addr_r;
                end else if (cnt_s == CNT_ONE) begin
                    ad_s = 1'b0;
                end else begin
                    ad_s = 1'b1;
                end
            end
            D_CS: begin
                cs_s = 1'b0;
            end
            D_STB: begin
                cs_s = 1'b0;
                if (we_r) begin
                    wr_s    = 1'b0;
                    adoe_s  = 1'b1;
                    adout_s = wdata_r;
                end else begin
                    rd_s = 1'b0;
                end
            end
            D_END: begin
                if (cnt_s == CNT_ZERO) begin
                    cs_s = 1'b0;
                    if (we_r) begin
                        adoe_s  = 1'b1;
                        adout_s = wdata_r;
                    end else begin
                        adoe_s = 1'b0;
                    end
                end else begin
                    cs_s = 1'b1;
                end
            end
            default: begin
                ad_s = 1'b1;
            end
        endcase
        ack_s  = (state_s == DONE) ? win_r : 3'b000;
        busy_s = (state_s != IDLE) && (state_s != DONE);
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered bus, handshake and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            ad    <= 1'b1;
            cs    <= 1'b1;
            wr    <= 1'b1;
            rd    <= 1'b1;
            adout <= BUS_IDLE;
            adoe  <= 1'b0;
            ack   <= 3'b000;
            busy  <= 1'b0;
        end else begin
            ad    <= ad_s;
            cs    <= cs_s;
            wr    <= wr_s;
            rd    <= rd_s;
            adout <= adout_s;
            adoe  <= adoe_s;
            ack   <= ack_s;
            busy  <= busy_s;
        end
    end

    // Read data is sampled at the end of the last rd-low cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= 8'h00;
        end else if ((state_r == D_STB) && (cnt_r == DATA_LAST) && !we_r) begin
            rdata <= adin;
        end else begin
            rdata <= rdata;
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_arbiter
// Transaction-level model of the RTC bus timeline (offset since grant),
// compared against the DUT every cycle, plus directed literal scenarios and a
// randomized run.
// -----------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

    localparam int AH     = 5;
    localparam int DH     = 5;
    localparam int G      = 8;
    // Offsets from the grant cycle (offset 0)
    localparam int D0     = AH + 6 + G;     // data-phase cs falls
    localparam int DONE_O = D0 + DH + 3;    // ack cycle

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req, we;
    logic [23:0] addr, wdata;
    logic [7:0]  adin;
    logic [2:0]  ack;
    logic [7:0]  rdata, adout;
    logic        busy, ad, cs, wr, rd, adoe;

    always #5 clock = ~clock;

    rtc_bus_arbiter #(.ADDR_HOLD(AH), .DATA_HOLD(DH), .GAP(G)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy), .ad(ad),
        .cs(cs), .wr(wr), .rd(rd), .adout(adout), .adoe(adoe), .adin(adin)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    bit         m_valid = 1'b0;
    bit         m_act   = 1'b0;
    int         m_o     = 0;
    int         m_win   = 0;
    int         m_ptr   = 0;
    bit         m_we    = 1'b0;
    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_rdata = 8'h00;

    // Running monitor totals (stimulus takes snapshots and differences)
    int         t_wra = 0, t_wrd = 0, t_rd = 0;
    int         t_ack[3] = '{0, 0, 0};
    logic [7:0] t_addr_seen = 8'h00, t_data_seen = 8'h00, t_rdata_ack = 8'h00;
    int         ack_q[$];

    // Per-cycle compare, monitor, then advance the model
    initial forever begin
        logic       e_ad, e_cs, e_wr, e_rd, e_oe, e_busy;
        logic [7:0] e_out;
        logic [2:0] e_ack;
        @(negedge clock);
        if (m_valid) begin
            e_ad = 1'b1; e_cs = 1'b1; e_wr = 1'b1; e_rd = 1'b1;
            e_oe = 1'b0; e_out = 8'hFF; e_ack = 3'b000; e_busy = 1'b0;
            if (m_act) begin
                e_busy = (m_o != DONE_O);
                if (m_o >= 1 && m_o <= AH + 4) e_ad = 1'b0;
                if (m_o >= 2 && m_o <= AH + 3) e_cs = 1'b0;
                if (m_o >= 3 && m_o <= AH + 2) e_wr = 1'b0;
                if (m_o >= 3 && m_o <= AH + 3) begin e_oe = 1'b1; e_out = m_addr; end
                if (m_o >= D0 && m_o <= D0 + DH + 1) e_cs = 1'b0;
                if (m_o >= D0 + 1 && m_o <= D0 + DH) begin
                    if (m_we) e_wr = 1'b0; else e_rd = 1'b0;
                end
                if (m_we && m_o >= D0 + 1 && m_o <= D0 + DH + 1) begin
                    e_oe = 1'b1; e_out = m_wdata;
                end
                if (m_o == DONE_O) e_ack[m_win] = 1'b1;
            end
            check("strobes", {ad, cs, wr, rd}, {e_ad, e_cs, e_wr, e_rd});
            check("adout", adout, e_out);
            check("adoe", adoe, e_oe);
            check("ack", ack, e_ack);
            check("busy", busy, e_busy);
            check("rdata", rdata, m_rdata);
            check("wr_rd_excl", (!wr && !rd), 1'b0);
            check("adoe_in_read", (!rd && adoe), 1'b0);

            if (!wr && !ad) begin t_wra++; t_addr_seen = adout; end
            if (!wr && ad)  begin t_wrd++; t_data_seen = adout; end
            if (!rd) t_rd++;
            for (int i = 0; i < 3; i++) begin
                if (ack[i] === 1'b1) begin
                    t_ack[i]++;
                    ack_q.push_back(i);
                    t_rdata_ack = rdata;
                end
            end
        end
        if (reset === 1'b1) begin
            m_valid = 1'b1; m_act = 1'b0; m_rdata = 8'h00; m_ptr = 0;
        end else if (m_valid) begin
            if (m_act) begin
                if (!m_we && m_o == D0 + DH) m_rdata = adin;
                if (m_o == DONE_O) m_act = 1'b0;
                else m_o++;
            end else if (|req) begin
                m_win = -1;
                for (int k = 0; k < 3; k++) begin
                    if (m_win < 0 && req[(m_ptr + k) % 3]) m_win = (m_ptr + k) % 3;
                end
`ifdef ARB_ROUND_ROBIN_EN
                m_ptr = (m_win + 1) % 3;
`endif
                m_act   = 1'b1;
                m_o     = 0;
                m_we    = we[m_win];
                m_addr  = addr[m_win*8 +: 8];
                m_wdata = wdata[m_win*8 +: 8];
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_ack(input int idx, input int base, input string name);
        int i;
        i = 0;
        while (t_ack[idx] == base && i < 200) begin
            step(1);
            i++;
        end
        check({name, "_ack_timeout"}, (t_ack[idx] == base), 1'b0);
    endtask

    int b_wra, b_wrd, b_rd, b_ack0, b_ack1, b_ack2, b_q;
    int exp_ord[4];
    int n_ord;

    task automatic snap();
        b_wra = t_wra; b_wrd = t_wrd; b_rd = t_rd;
        b_ack0 = t_ack[0]; b_ack1 = t_ack[1]; b_ack2 = t_ack[2];
        b_q = ack_q.size();
    endtask

    initial begin
        reset = 1'b1; req = 3'b000; we = 3'b000; addr = 24'h0; wdata = 24'h0; adin = 8'h00;
        step(3);
        // Reset state held while reset is high
        check("rst_strobes", {ad, cs, wr, rd}, 4'hF);
        check("rst_adout", adout, 8'hFF);
        check("rst_adoe", adoe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", ack, 3'b000);
        check("rst_rdata", rdata, 8'h00);
        reset = 1'b0;
        step(2);

        // Single write from requester 0
        snap();
        req = 3'b001; we = 3'b001; addr = 24'h00000B; wdata = 24'h000086;
        step(3);
        req = 3'b000;
        wait_ack(0, b_ack0, "wr0");
        step(3);
        check("wr0_addr_cycles", t_wra - b_wra, 5);
        check("wr0_addr_val", t_addr_seen, 8'h0B);
        check("wr0_data_cycles", t_wrd - b_wrd, 5);
        check("wr0_data_val", t_data_seen, 8'h86);
        check("wr0_rd_cycles", t_rd - b_rd, 0);
        check("wr0_ack_count", t_ack[0] - b_ack0, 1);

        // Single read from requester 2
        snap();
        req = 3'b100; we = 3'b000; addr = 24'h00_5A_33; adin = 8'h45;
        step(3);
        req = 3'b000; addr = 24'hFFFFFF;
        wait_ack(2, b_ack2, "rd2");
        check("rd2_rdata_at_ack", t_rdata_ack, 8'h45);
        step(3);
        check("rd2_rd_cycles", t_rd - b_rd, 5);
        check("rd2_wr_data_cycles", t_wrd - b_wrd, 0);
        check("rd2_addr_val", t_addr_seen, 8'h00);
        check("rd2_ack_count", t_ack[2] - b_ack2, 1);

        // Arbitration with all requests held
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = '{0, 1, 2, 0}; n_ord = 4;
`else
        exp_ord = '{0, 0, 0, 0}; n_ord = 3;
`endif
        snap();
        req = 3'b111; we = 3'b101; addr = 24'h332211; wdata = 24'h665544;
        for (int i = 0; i < 400 && (ack_q.size() - b_q) < n_ord; i++) step(1);
        req = 3'b000;
        check("arb_ack_timeout", ((ack_q.size() - b_q) < n_ord), 1'b0);
        for (int i = 0; i < n_ord; i++) begin
            if (b_q + i < ack_q.size()) check("arb_order", ack_q[b_q + i], exp_ord[i]);
        end
        step(40);

        // Reset during the data strobe aborts without ack
        snap();
        req = 3'b010; we = 3'b010; addr = 24'h00_7700; wdata = 24'h00_C300;
        for (int i = 0; i < 100 && t_wrd == b_wrd; i++) step(1);
        check("mid_rst_reach_dstb", (t_wrd == b_wrd), 1'b0);
        reset = 1'b1;
        step(1);
        check("mid_rst_strobes", {ad, cs, wr, rd}, 4'hF);
        check("mid_rst_adout", adout, 8'hFF);
        check("mid_rst_adoe", adoe, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        req = 3'b000;
        reset = 1'b0;
        step(40);
        check("mid_rst_no_ack", t_ack[1] - b_ack1, 0);

        // Request dropped during the gap still completes
        snap();
        req = 3'b010; we = 3'b000; addr = 24'h00_1200; adin = 8'h9C;
        for (int i = 0; i < 100 && (t_wra - b_wra) < AH; i++) step(1);
        step(5);
        req = 3'b000;
        wait_ack(1, b_ack1, "drop1");
        check("drop1_rdata", t_rdata_ack, 8'h9C);
        step(3);
        check("drop1_ack_count", t_ack[1] - b_ack1, 1);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) we = 3'($urandom_range(0, 7));
            addr  = 24'($urandom);
            wdata = 24'($urandom);
            adin  = 8'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        req = 3'b000;
        step(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
